// File: rtl/mesa_lb_if.sv
// Mesa local bus port bundle shared by the arbiter masters and slave.
// master drives requests; slave returns read data.
interface mesa_lb_if;
  logic        wr;
  logic        rd;
  logic [31:0] addr;
  logic [31:0] wr_d;
  logic [31:0] rd_d;
  logic        rd_rdy;

  modport master (
    output wr, rd, addr, wr_d,
    input  rd_d, rd_rdy
  );

  modport slave (
    input  wr, rd, addr, wr_d,
    output rd_d, rd_rdy
  );
endinterface

// File: rtl/mesa_lb_arbiter.sv
// Two-master round-robin arbiter onto one Mesa local bus slave port.
// Optional read timeout enabled by defining LB_ARB_TIMEOUT_EN.
module mesa_lb_arbiter #(
  parameter int          RD_TIMEOUT_CYC = 255,
  parameter logic [31:0] TIMEOUT_DATA   = 32'hDEADBEEF
) (
  input  logic        clk,
  input  logic        reset_l,
  mesa_lb_if.slave    m0,
  mesa_lb_if.slave    m1,
  mesa_lb_if.master   s,
  output logic        m0_busy,
  output logic        m1_busy,
  input  logic        ovfl_clr,
  output logic [1:0]  ovfl
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR      = 2'd1,
    RD_WAIT = 2'd2
  } state_t;

  typedef struct packed {
    logic        vld;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
  } req_t;

  state_t      st_q, st_d;
  req_t        pend_q [2];
  req_t        pend_d [2];
  logic        own_q, own_d;
  logic        prio_q, prio_d;
  logic        s_wr_q, s_wr_d;
  logic        s_rd_q, s_rd_d;
  logic [31:0] s_addr_q, s_addr_d;
  logic [31:0] s_wd_q, s_wd_d;
  logic [31:0] rdd_q [2];
  logic [31:0] rdd_d [2];
  logic [1:0]  rdy_q, rdy_d;
  logic [1:0]  busy_q, busy_d;
  logic [1:0]  ovfl_q, ovfl_d;

  logic [1:0]  req_wr, req_rd;
  logic [31:0] req_addr [2];
  logic [31:0] req_wd [2];
  logic        any_pend, gnt;
  logic        tmo, rd_hit, rd_done;
  logic [31:0] ret_d;

  assign req_wr      = {m1.wr, m0.wr};
  assign req_rd      = {m1.rd, m0.rd};
  assign req_addr[0] = m0.addr;
  assign req_addr[1] = m1.addr;
  assign req_wd[0]   = m0.wr_d;
  assign req_wd[1]   = m1.wr_d;

  // rdy during the s_lb_rd cycle belongs to no accepted read
  assign rd_hit  = (st_q == RD_WAIT) && !s_rd_q && s.rd_rdy;
  assign rd_done = rd_hit | tmo;
  assign ret_d   = rd_hit ? s.rd_d : TIMEOUT_DATA;

`ifdef LB_ARB_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(RD_TIMEOUT_CYC - 1);
  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = (st_q == RD_WAIT) ? cnt_q + 16'd1 : '0;
  end

  assign tmo = (st_q == RD_WAIT) && (cnt_q == TMO_LAST);

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end
`else
  logic unused_cfg;
  assign tmo        = 1'b0;
  assign unused_cfg = ^RD_TIMEOUT_CYC;
`endif

  always_comb begin
    any_pend = pend_q[0].vld | pend_q[1].vld;
    gnt      = 1'b0;
    unique case (1'b1)
      pend_q[0].vld && pend_q[1].vld:  gnt = prio_q;
      pend_q[1].vld && !pend_q[0].vld: gnt = 1'b1;
      default:                         gnt = 1'b0;
    endcase
  end

  always_comb begin
    st_d = st_q;
    unique case (st_q)
      IDLE:    if (any_pend) st_d = pend_q[gnt].wr ? WR : RD_WAIT;
      WR:      st_d = IDLE;
      RD_WAIT: if (rd_done) st_d = IDLE;
      default: st_d = IDLE;
    endcase
  end

  always_comb begin
    pend_d   = pend_q;
    own_d    = own_q;
    prio_d   = prio_q;
    s_wr_d   = 1'b0;
    s_rd_d   = 1'b0;
    s_addr_d = s_addr_q;
    s_wd_d   = s_wd_q;
    rdd_d    = rdd_q;
    rdy_d    = '0;
    busy_d   = '0;
    ovfl_d   = ovfl_clr ? 2'b00 : ovfl_q;

    for (int n = 0; n < 2; n++) begin
      if (req_wr[n] | req_rd[n]) begin
        if (pend_q[n].vld || (st_q != IDLE && own_q == n[0])) begin
          ovfl_d[n] = 1'b1;
        end else begin
          pend_d[n] = '{vld: 1'b1, wr: req_wr[n],
                        addr: req_addr[n], data: req_wd[n]};
          if (req_wr[n] && req_rd[n]) ovfl_d[n] = 1'b1;
        end
      end
    end

    if (st_q == IDLE && any_pend) begin
      own_d           = gnt;
      pend_d[gnt].vld = 1'b0;
      s_addr_d        = pend_q[gnt].addr;
      s_wd_d          = pend_q[gnt].data;
      s_wr_d          = pend_q[gnt].wr;
      s_rd_d          = !pend_q[gnt].wr;
      if (pend_q[0].vld && pend_q[1].vld) prio_d = ~prio_q;
    end

    if (rd_done) begin
      rdd_d[own_q] = ret_d;
      rdy_d[own_q] = 1'b1;
    end

    for (int n = 0; n < 2; n++) begin
      busy_d[n] = pend_d[n].vld | (st_d != IDLE && own_d == n[0]);
    end
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      st_q      <= IDLE;
      pend_q[0] <= '0;
      pend_q[1] <= '0;
      own_q     <= 1'b0;
      prio_q    <= 1'b0;
      s_wr_q    <= 1'b0;
      s_rd_q    <= 1'b0;
      s_addr_q  <= '0;
      s_wd_q    <= '0;
      rdd_q[0]  <= '0;
      rdd_q[1]  <= '0;
      rdy_q     <= '0;
      busy_q    <= '0;
      ovfl_q    <= '0;
    end else begin
      st_q      <= st_d;
      pend_q    <= pend_d;
      own_q     <= own_d;
      prio_q    <= prio_d;
      s_wr_q    <= s_wr_d;
      s_rd_q    <= s_rd_d;
      s_addr_q  <= s_addr_d;
      s_wd_q    <= s_wd_d;
      rdd_q     <= rdd_d;
      rdy_q     <= rdy_d;
      busy_q    <= busy_d;
      ovfl_q    <= ovfl_d;
    end
  end

  assign m0.rd_d   = rdd_q[0];
  assign m0.rd_rdy = rdy_q[0];
  assign m1.rd_d   = rdd_q[1];
  assign m1.rd_rdy = rdy_q[1];
  assign m0_busy   = busy_q[0];
  assign m1_busy   = busy_q[1];
  assign s.wr      = s_wr_q;
  assign s.rd      = s_rd_q;
  assign s.addr    = s_addr_q;
  assign s.wr_d    = s_wd_q;
  assign ovfl      = ovfl_q;

endmodule

// File: tb/tb_mesa_lb_arbiter.sv
// Directed bench for mesa_lb_arbiter: writes, round-robin reads,
// drops/overflow, stray read-ready, reset abort, optional timeout.
module tb_mesa_lb_arbiter;
  logic       clk = 1'b0;
  logic       reset_l = 1'b0;
  logic       ovfl_clr = 1'b0;
  logic       m0_busy, m1_busy;
  logic [1:0] ovfl;
  int         vecs = 0;
  int         miss = 0;

  mesa_lb_if m0_if ();
  mesa_lb_if m1_if ();
  mesa_lb_if s_if ();

  mesa_lb_arbiter #(.RD_TIMEOUT_CYC(8)) dut (
    .clk      (clk),
    .reset_l  (reset_l),
    .m0       (m0_if.slave),
    .m1       (m1_if.slave),
    .s        (s_if.master),
    .m0_busy  (m0_busy),
    .m1_busy  (m1_busy),
    .ovfl_clr (ovfl_clr),
    .ovfl     (ovfl)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vecs++;
    assert (obs === exp)
    else begin
      miss++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic m0_req(input logic w, input logic r,
                        input logic [31:0] a, input logic [31:0] d);
    m0_if.wr = w; m0_if.rd = r; m0_if.addr = a; m0_if.wr_d = d;
  endtask

  task automatic m1_req(input logic w, input logic r,
                        input logic [31:0] a, input logic [31:0] d);
    m1_if.wr = w; m1_if.rd = r; m1_if.addr = a; m1_if.wr_d = d;
  endtask

  task automatic slv(input logic v, input logic [31:0] d);
    s_if.rd_rdy = v; s_if.rd_d = d;
  endtask

  initial begin
    m0_req(0, 0, 0, 0);
    m1_req(0, 0, 0, 0);
    slv(0, 0);
    cyc(3);
    chk("rst_s_wr", 32'(s_if.wr), 0);
    chk("rst_s_rd", 32'(s_if.rd), 0);
    chk("rst_s_addr", s_if.addr, 0);
    chk("rst_busy", 32'({m1_busy, m0_busy}), 0);
    chk("rst_ovfl", 32'(ovfl), 0);
    chk("rst_rdy", 32'({m1_if.rd_rdy, m0_if.rd_rdy}), 0);
    reset_l = 1'b1;
    cyc(1);

    // m0 single write
    m0_req(1, 0, 32'h10, 32'hA5A5A5A5);
    cyc(1);
    m0_req(0, 0, 0, 0);
    chk("wr_busy_k", 32'(m0_busy), 1);
    chk("wr_s_wr_k", 32'(s_if.wr), 0);
    cyc(1);
    chk("wr_s_wr", 32'(s_if.wr), 1);
    chk("wr_addr", s_if.addr, 32'h10);
    chk("wr_data", s_if.wr_d, 32'hA5A5A5A5);
    chk("wr_busy_k1", 32'(m0_busy), 1);
    cyc(1);
    chk("wr_s_wr_off", 32'(s_if.wr), 0);
    chk("wr_busy_done", 32'(m0_busy), 0);
    chk("wr_addr_hold", s_if.addr, 32'h10);

    // simultaneous reads, m0 has priority
    m0_req(0, 1, 32'h100, 0);
    m1_req(0, 1, 32'h200, 0);
    cyc(1);
    m0_req(0, 0, 0, 0);
    m1_req(0, 0, 0, 0);
    chk("rr1_busy", 32'({m1_busy, m0_busy}), 32'h3);
    cyc(1);
    chk("rr1_s_rd", 32'(s_if.rd), 1);
    chk("rr1_addr0", s_if.addr, 32'h100);
    cyc(1);
    chk("rr1_s_rd_off", 32'(s_if.rd), 0);
    cyc(1);
    slv(1, 32'h11);
    cyc(1);
    slv(0, 0);
    chk("rr1_m0_rdy", 32'(m0_if.rd_rdy), 1);
    chk("rr1_m0_d", m0_if.rd_d, 32'h11);
    chk("rr1_m1_rdy0", 32'(m1_if.rd_rdy), 0);
    chk("rr1_m0_busy", 32'(m0_busy), 0);
    cyc(1);
    chk("rr1_m0_pulse", 32'(m0_if.rd_rdy), 0);
    chk("rr1_addr1", s_if.addr, 32'h200);
    chk("rr1_s_rd1", 32'(s_if.rd), 1);
    cyc(2);
    slv(1, 32'h22);
    cyc(1);
    slv(0, 0);
    chk("rr1_m1_rdy", 32'(m1_if.rd_rdy), 1);
    chk("rr1_m1_d", m1_if.rd_d, 32'h22);
    chk("rr1_m0_hold", m0_if.rd_d, 32'h11);
    chk("rr1_m1_busy", 32'(m1_busy), 0);
    cyc(1);

    // second pair, m1 now has priority
    m0_req(0, 1, 32'h104, 0);
    m1_req(0, 1, 32'h204, 0);
    cyc(1);
    m0_req(0, 0, 0, 0);
    m1_req(0, 0, 0, 0);
    cyc(1);
    chk("rr2_first", s_if.addr, 32'h204);
    cyc(2);
    slv(1, 32'h33);
    cyc(1);
    slv(0, 0);
    chk("rr2_m1_d", m1_if.rd_d, 32'h33);
    chk("rr2_m0_rdy0", 32'(m0_if.rd_rdy), 0);
    cyc(1);
    chk("rr2_second", s_if.addr, 32'h104);
    cyc(2);
    slv(1, 32'h44);
    cyc(1);
    slv(0, 0);
    chk("rr2_m0_d", m0_if.rd_d, 32'h44);
    chk("rr2_m1_hold", m1_if.rd_d, 32'h33);
    cyc(1);

    // m1 back-to-back writes: second dropped
    m1_req(1, 0, 32'h30, 32'h1);
    cyc(1);
    m1_req(1, 0, 32'h34, 32'h2);
    cyc(1);
    m1_req(0, 0, 0, 0);
    chk("drop_s_wr", 32'(s_if.wr), 1);
    chk("drop_addr", s_if.addr, 32'h30);
    chk("drop_ovfl", 32'(ovfl), 32'h2);
    cyc(1);
    chk("drop_busy", 32'(m1_busy), 0);
    chk("drop_sticky", 32'(ovfl), 32'h2);
    cyc(1);
    chk("drop_no_2nd", 32'(s_if.wr), 0);
    ovfl_clr = 1'b1;
    cyc(1);
    ovfl_clr = 1'b0;
    chk("ovfl_clr", 32'(ovfl), 0);

    // stray slave ready while idle
    slv(1, 32'h99);
    cyc(1);
    slv(0, 0);
    chk("stray_rdy", 32'({m1_if.rd_rdy, m0_if.rd_rdy}), 0);
    chk("stray_m0_d", m0_if.rd_d, 32'h44);
    chk("stray_m1_d", m1_if.rd_d, 32'h33);

    // wr+rd same cycle: write kept, read dropped
    m0_req(1, 1, 32'h50, 32'h7);
    cyc(1);
    m0_req(0, 0, 0, 0);
    chk("wrrd_ovfl", 32'(ovfl), 32'h1);
    cyc(1);
    chk("wrrd_wr", 32'({s_if.wr, s_if.rd}), 32'h2);
    chk("wrrd_addr", s_if.addr, 32'h50);
    cyc(1);
    // clear collides with a new drop: bit stays
    ovfl_clr = 1'b1;
    m0_req(1, 1, 32'h54, 32'h8);
    cyc(1);
    ovfl_clr = 1'b0;
    m0_req(0, 0, 0, 0);
    chk("clr_vs_drop", 32'(ovfl), 32'h1);
    cyc(1);
    chk("clr_vs_wr", s_if.addr, 32'h54);
    cyc(1);
    ovfl_clr = 1'b1;
    cyc(1);
    ovfl_clr = 1'b0;
    chk("ovfl_clr2", 32'(ovfl), 0);

    // reset mid read
    m0_req(0, 1, 32'h60, 0);
    cyc(1);
    m0_req(0, 0, 0, 0);
    cyc(2);
    chk("abort_pre_busy", 32'(m0_busy), 1);
    reset_l = 1'b0;
    #1;
    chk("abort_busy", 32'(m0_busy), 0);
    chk("abort_s_rd", 32'(s_if.rd), 0);
    cyc(1);
    reset_l = 1'b1;
    cyc(1);
    slv(1, 32'h77);
    cyc(1);
    slv(0, 0);
    chk("late_rdy", 32'(m0_if.rd_rdy), 0);
    chk("late_busy", 32'(m0_busy), 0);
    chk("late_d", m0_if.rd_d, 0);

`ifdef LB_ARB_TIMEOUT_EN
    m0_req(0, 1, 32'h70, 0);
    cyc(1);
    m0_req(0, 0, 0, 0);
    cyc(8);
    chk("tmo_early", 32'(m0_if.rd_rdy), 0);
    cyc(1);
    chk("tmo_rdy", 32'(m0_if.rd_rdy), 1);
    chk("tmo_d", m0_if.rd_d, 32'hDEADBEEF);
    cyc(1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end
endmodule
